// File: rtl/regfile_pkg.sv
// Shared types for the register-file sequencer: op codes,
// FSM states and default bus widths.
package regfile_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [2:0] {
    MOV     = 3'd0,
    ADD     = 3'd1,
    SUB     = 3'd2,
    AND     = 3'd3,
    OR      = 3'd4,
    XOR     = 3'd5,
    SWAP    = 3'd6,
    ILLEGAL = 3'd7
  } rf_op_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WRITE  = 3'd2,
    WRITE2 = 3'd3,
    DONE   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/rf_alu.sv
// Combinational ALU for the sequencer.
// Ports: op, x, y in; result, carry out (carry = NOT borrow on SUB).
module rf_alu
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  rf_op_t           op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    unique case (op)
      MOV, SWAP: result = x;
      ADD: begin
        sum    = {1'b0, x} + {1'b0, y};
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      SUB: begin
        sum    = {1'b0, x} + {1'b0, ~y}
               + (WIDTH+1)'(1);
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      AND:     result = x & y;
      OR:      result = x | y;
      XOR:     result = x ^ y;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Drives register_file control lines to run one command at a time.
// Ports: cmd_* in (valid/ready), rsp_* out (valid/ready),
// a/b read buses in, sel_a/sel_b/oe_a/oe_b/ld/in control out.
module regfile_sequencer
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src_a,
  input  logic [ADDR_W-1:0] cmd_src_b,
  input  logic [ADDR_W-1:0] cmd_dst,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_zero,
  output logic              rsp_carry,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [ADDR_W-1:0] sel_a,
  output logic [ADDR_W-1:0] sel_b,
  output logic              oe_a,
  output logic              oe_b,
  output logic              ld,
  output logic [WIDTH-1:0]  in
);

  seq_state_t        state;
  rf_op_t            op_q;
  rf_op_t            cmd_op_e;
  logic [ADDR_W-1:0] src_a_q;
  logic [ADDR_W-1:0] src_b_q;
  logic [ADDR_W-1:0] dst_q;
  logic [WIDTH-1:0]  opa_q;
  logic [WIDTH-1:0]  res_q;
  logic              carry_q;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_carry;
  logic              is_swap;

  assign cmd_op_e = rf_op_t'(cmd_op);
  assign is_swap  = (op_q == SWAP);

  // ALU sees the live buses; its output is only
  // registered in READ, so X/Z elsewhere is ignored.
  rf_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op     (op_q),
    .x      (a),
    .y      (b),
    .result (alu_res),
    .carry  (alu_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= MOV;
      src_a_q    <= '0;
      src_b_q    <= '0;
      dst_q      <= '0;
      opa_q      <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
      sel_a      <= '0;
      sel_b      <= '0;
      oe_a       <= 1'b0;
      oe_b       <= 1'b0;
      ld         <= 1'b0;
      in         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op_e;
            src_a_q   <= cmd_src_a;
            src_b_q   <= cmd_src_b;
            dst_q     <= cmd_dst;
            cmd_ready <= 1'b0;
            if (cmd_op_e == ILLEGAL) begin
              state      <= DONE;
              rsp_valid  <= 1'b1;
              rsp_result <= '0;
              rsp_zero   <= 1'b1;
              rsp_carry  <= 1'b0;
            end else begin
              state <= READ;
              sel_a <= cmd_src_a;
              sel_b <= cmd_src_b;
              oe_a  <= 1'b1;
              oe_b  <= (cmd_op_e != MOV);
            end
          end
        end
        READ: begin
          opa_q   <= a;
          res_q   <= is_swap ? a : alu_res;
          carry_q <= alu_carry;
          oe_a    <= 1'b0;
          oe_b    <= 1'b0;
          ld      <= 1'b1;
          sel_b   <= '0;
          sel_a   <= is_swap ? src_a_q : dst_q;
          in      <= is_swap ? b : alu_res;
          state   <= WRITE;
        end
        WRITE: begin
          if (is_swap) begin
            state <= WRITE2;
            sel_a <= src_b_q;
            in    <= opa_q;
          end else begin
            state      <= DONE;
            ld         <= 1'b0;
            sel_a      <= '0;
            in         <= '0;
            rsp_valid  <= 1'b1;
            rsp_result <= res_q;
            rsp_zero   <= (res_q == '0);
            rsp_carry  <= carry_q;
          end
        end
        WRITE2: begin
          state      <= DONE;
          ld         <= 1'b0;
          sel_a      <= '0;
          in         <= '0;
          rsp_valid  <= 1'b1;
          rsp_result <= res_q;
          rsp_zero   <= (res_q == '0);
          rsp_carry  <= carry_q;
        end
        DONE: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          oe_a      <= 1'b0;
          oe_b      <= 1'b0;
          ld        <= 1'b0;
        end
      endcase
    end
  end

endmodule
